// File: rtl/clefia_rk_gen_128.sv
// CLEFIA-128 round-key sequencer: walks CON entries 0x0C..0x1D, mixes in L/K, streams 18 key pairs.
// Optional macro CLEFIA_RK_REV_EN selects decryption order (buffered FILL then reverse DRAIN).
module clefia_rk_gen_128 (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [127:0] key_i,
  input  logic [127:0] lkey_i,
  output logic [4:0]   rom_round_o,
  input  logic [63:0]  rom_con_i,
  output logic [63:0]  rk_o,
  output logic [4:0]   rk_idx_o,
  output logic         rk_valid_o,
  input  logic         rk_ready_i,
  output logic         busy_o,
  output logic         done_o
);

  // Handshake: a pair transfers on any rising edge where rk_valid_o and rk_ready_i are both high;
  // rk_o/rk_idx_o are held stable while rk_valid_o is high and rk_ready_i is low.

  localparam logic [1:0] S_IDLE  = 2'd0;
`ifdef CLEFIA_RK_REV_EN
  localparam logic [1:0] S_FILL  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;
`else
  localparam logic [1:0] S_RUN   = 2'd1;
`endif

  localparam logic [4:0] LAST_J   = 5'd17;
  localparam logic [4:0] CON_BASE = 5'h0C;

  logic [1:0]   state_q, state_d;
  logic [4:0]   j_q, j_d;
  logic [127:0] k_q, k_d;
  logic [127:0] l_q, l_d;
  logic         done_q, done_d;

  logic [63:0]  l_half, k_half, pair_t, rk_data;
  logic [127:0] l_sigma;

  // j[0] selects the 64-bit half, j[1] is the parity of the iteration i = j>>1.
  assign l_half  = j_q[0] ? l_q[63:0] : l_q[127:64];
  assign k_half  = j_q[0] ? k_q[63:0] : k_q[127:64];
  assign pair_t  = l_half ^ rom_con_i ^ (j_q[1] ? k_half : 64'd0);
  assign l_sigma = {l_q[120:64], l_q[6:0], l_q[127:121], l_q[63:7]};

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    k_d     = k_q;
    l_d     = l_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          k_d = key_i;
          l_d = lkey_i;
          j_d = 5'd0;
`ifdef CLEFIA_RK_REV_EN
          state_d = S_FILL;
`else
          state_d = S_RUN;
`endif
        end
      end
`ifdef CLEFIA_RK_REV_EN
      S_FILL: begin
        if (j_q[0]) l_d = l_sigma;
        if (j_q == LAST_J) state_d = S_DRAIN;
        else               j_d     = j_q + 5'd1;
      end
      S_DRAIN: begin
        if (rk_ready_i) begin
          if (j_q == 5'd0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            j_d = j_q - 5'd1;
          end
        end
      end
`else
      S_RUN: begin
        if (rk_ready_i) begin
          if (j_q[0]) l_d = l_sigma;
          if (j_q == LAST_J) begin
            state_d = S_IDLE;
            j_d     = 5'd0;
            done_d  = 1'b1;
          end else begin
            j_d = j_q + 5'd1;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      j_q     <= 5'd0;
      k_q     <= 128'd0;
      l_q     <= 128'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      k_q     <= k_d;
      l_q     <= l_d;
      done_q  <= done_d;
    end
  end

`ifdef CLEFIA_RK_REV_EN
  // Pair store is deliberately left out of reset; it is fully rewritten by every FILL.
  logic [63:0] rev_buf_q [0:17];

  always_ff @(posedge clk) begin
    if (state_q == S_FILL) rev_buf_q[j_q] <= pair_t;
  end

  assign rk_valid_o = (state_q == S_DRAIN);
  assign rk_data    = rev_buf_q[j_q];
`else
  assign rk_valid_o = (state_q == S_RUN);
  assign rk_data    = pair_t;
`endif

  assign rk_o        = rk_valid_o ? rk_data : 64'd0;
  assign rk_idx_o    = rk_valid_o ? j_q : 5'd0;
  assign rom_round_o = (state_q == S_IDLE) ? CON_BASE : (CON_BASE + j_q);
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;

endmodule

// File: tb/tb_clefia_rk_gen_128.sv
// Bench for clefia_rk_gen_128: ROM stand-in, pair-sequence model with expected queue, directed runs.
// Honours CLEFIA_RK_REV_EN to expect reverse order and the longer first-valid latency.
module tb_clefia_rk_gen_128;

`ifdef CLEFIA_RK_REV_EN
  localparam int EXP_LAT  = 19;
  localparam int LAST_IDX = 0;
`else
  localparam int EXP_LAT  = 1;
  localparam int LAST_IDX = 17;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key = '0;
  logic [127:0] lkey = '0;
  logic [4:0]   rom_round;
  logic [63:0]  rom_con;
  logic [63:0]  rk;
  logic [4:0]   rk_idx;
  logic         rk_valid;
  logic         rk_ready = 1'b1;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clefia_rk_gen_128 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .key_i       (key),
    .lkey_i      (lkey),
    .rom_round_o (rom_round),
    .rom_con_i   (rom_con),
    .rk_o        (rk),
    .rk_idx_o    (rk_idx),
    .rk_valid_o  (rk_valid),
    .rk_ready_i  (rk_ready),
    .busy_o      (busy),
    .done_o      (done)
  );

  // Constant ROM: entries 0x0C, 0x0D, 0x0E and 0x1D carry the real CLEFIA values.
  logic [63:0] rom_mem [0:31];
  assign rom_con = rom_mem[rom_round];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  logic [4:0]  idx_q[$];
  logic [63:0] cap [0:31];
  int          last_idx = -1;
  bit          exp_done = 1'b0;
  bit          load_tog = 1'b0;
  bit          load_seen = 1'b0;

  task automatic build_model(input logic [127:0] k, input logic [127:0] l);
    logic [127:0] lm;
    logic [63:0]  pairs [0:17];
    logic [63:0]  t;
    lm = l;
    for (int j = 0; j < 18; j++) begin
      t = ((j % 2) == 1 ? lm[63:0] : lm[127:64]) ^ rom_mem[12 + j];
      if (((j / 2) % 2) == 1) t = t ^ ((j % 2) == 1 ? k[63:0] : k[127:64]);
      pairs[j] = t;
      if ((j % 2) == 1) lm = {lm[120:64], lm[6:0], lm[127:121], lm[63:7]};
    end
    for (int n = 0; n < 18; n++) begin
`ifdef CLEFIA_RK_REV_EN
      exp_q.push_back(pairs[17 - n]);
      idx_q.push_back(5'(17 - n));
`else
      exp_q.push_back(pairs[n]);
      idx_q.push_back(5'(n));
`endif
    end
  endtask

  always @(negedge clk) begin
    if (load_tog != load_seen) begin
      load_seen = load_tog;
      build_model(key, lkey);
    end
    if (!rst_n) begin
      chk("reset_ctrl", {51'd0, rk_valid, busy, done, rk_idx, rom_round}, {51'd0, 3'b000, 5'd0, 5'h0C});
      chk("reset_rk", rk, 64'd0);
      exp_q.delete();
      idx_q.delete();
      exp_done = 1'b0;
    end else begin
      chk("done_pulse", {63'd0, done}, {63'd0, exp_done});
      exp_done = 1'b0;
      if (rk_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", {63'd0, rk_valid}, 64'd0);
        end else begin
          chk("rk", rk, exp_q[0]);
          chk("rk_idx", {59'd0, rk_idx}, {59'd0, idx_q[0]});
`ifndef CLEFIA_RK_REV_EN
          chk("rom_round", {59'd0, rom_round}, {59'd0, 5'h0C + idx_q[0]});
`endif
          if (rk_ready) begin
            cap[rk_idx] = rk;
            last_idx = int'(rk_idx);
            void'(exp_q.pop_front());
            void'(idx_q.pop_front());
            if (exp_q.size() == 0) exp_done = 1'b1;
          end
        end
      end else begin
        chk("rk_zero_when_invalid", rk, 64'd0);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run(input logic [127:0] k, input logic [127:0] l, input int stall_at,
                     input bit pulse_start, input int abort_at);
    int lat;
    int stall_cnt;
    bit fin;
    bit aborted;
    bit stall;
    key = k;
    lkey = l;
    load_tog = ~load_tog;
    rk_ready = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 1;
    while (!rk_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("first_valid_latency", 64'(lat), 64'(EXP_LAT));
    stall_cnt = 0;
    fin = 1'b0;
    aborted = 1'b0;
    for (int cyc = 0; cyc < 120 && !fin; cyc++) begin
      if (done) begin
        chk("busy_in_done_cycle", {63'd0, busy}, 64'd0);
        fin = 1'b1;
      end else if (abort_at >= 0 && rk_valid && int'(rk_idx) == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("reset_immediate_ctrl", {51'd0, rk_valid, busy, done, rk_idx, rom_round},
            {51'd0, 3'b000, 5'd0, 5'h0C});
        chk("reset_immediate_rk", rk, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        fin = 1'b1;
        aborted = 1'b1;
      end else begin
        stall = rk_valid && int'(rk_idx) == stall_at && stall_cnt < 3;
        if (stall) stall_cnt++;
        rk_ready = !stall;
        start = stall && pulse_start;
        @(posedge clk);
        #1;
      end
    end
    start = 1'b0;
    rk_ready = 1'b1;
    if (!fin) chk("run_timeout", 64'd0, 64'd1);
    if (!aborted) begin
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      chk("last_idx", 64'(last_idx), 64'(LAST_IDX));
      if (stall_at >= 0) chk("stall_cycles", 64'(stall_cnt), 64'd3);
    end
  endtask

  initial begin
    for (int e = 0; e < 32; e++) begin
      logic [4:0] ev;
      ev = e[4:0];
      rom_mem[e] = {27'h5A3C9E1, ev, 27'h2B7D4C6, ~ev};
    end
    rom_mem[12] = 64'h7C6F68E2104E8ECB;
    rom_mem[13] = 64'hD2263471BE07C765;
    rom_mem[14] = 64'h511A32083D3BFBE6;
    rom_mem[29] = 64'h1052B0987C73B3A7;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // zero keys
    run(128'd0, 128'd0, -1, 1'b0, -1);
    chk("zero_pair0", cap[0], 64'h7C6F68E2104E8ECB);
    chk("zero_pair1", cap[1], 64'hD2263471BE07C765);
    chk("zero_pair2", cap[2], 64'h511A32083D3BFBE6);
    chk("zero_pair17", cap[17], 64'h1052B0987C73B3A7);

    // K mixing, started in the done cycle of the previous run
    run({128{1'b1}}, 128'd0, -1, 1'b0, -1);
    chk("kmix_pair0", cap[0], 64'h7C6F68E2104E8ECB);
    chk("kmix_pair2", cap[2], 64'hAEE5CDF7C2C40419);

    // sigma moves L bit0 to bit64
    run(128'd0, 128'd1, -1, 1'b0, -1);
    chk("sigma_pair1", cap[1], 64'hD2263471BE07C764);
    chk("sigma_pair2", cap[2], 64'h511A32083D3BFBE7);

    // backpressure at j=5 with ignored start pulses
    run(128'd0, 128'd0, 5, 1'b1, -1);
    chk("stall_pair0", cap[0], 64'h7C6F68E2104E8ECB);
    chk("stall_pair5", cap[5], rom_mem[17]);

    // arbitrary keys, with a stall
    run(128'h0123456789ABCDEF_FEDCBA9876543210, 128'hA5A5F00F3C3C9669_5AA50FF0C3C36996,
        8, 1'b0, -1);

    // reset mid-stream, then restart
    run(128'd0, 128'd0, -1, 1'b0, 9);
    @(posedge clk);
    #1;
    run(128'd0, 128'd0, -1, 1'b0, -1);
    chk("restart_pair0", cap[0], 64'h7C6F68E2104E8ECB);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
